ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Inhibits the clock, issues a request-to-send, shifts a byte plus odd parity on device clock edges, checks the ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int MAXC = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE} state_t;

  state_t          state;
  logic [1:0]      clk_sync, dat_sync;
  logic [15:0]     clk_hist, dat_hist;
  logic            clk_f, dat_f, clk_f_d;
  logic            fall;
  logic [10:0]     frame;
  logic [3:0]      bit_cnt;
  logic [CW-1:0]   cnt;

  // Two-flop synchronizer ahead of the 16-sample agreement filter; the line is only ever sampled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_hist <= '1;
      dat_hist <= '1;
      clk_f    <= 1'b1;
      dat_f    <= 1'b1;
      clk_f_d  <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      clk_hist <= {clk_hist[14:0], clk_sync[1]};
      dat_hist <= {dat_hist[14:0], dat_sync[1]};
      if (&clk_hist)       clk_f <= 1'b1;
      else if (~|clk_hist) clk_f <= 1'b0;
      if (&dat_hist)       dat_f <= 1'b1;
      else if (~|dat_hist) dat_f <= 1'b0;
      clk_f_d  <= clk_f;
    end
  end

  assign fall = clk_f_d & ~clk_f;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      frame      <= '0;
      bit_cnt    <= '0;
      cnt        <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start) begin
            frame      <= {1'b1, ~^tx_data, tx_data, 1'b0};
            tx_err     <= 1'b0;
            tx_busy    <= 1'b1;
            cnt        <= '0;
            bit_cnt    <= '0;
            ps2_clk_oe <= 1'b1;
            ps2_dat_oe <= 1'b0;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          // Hold clock low for the full inhibit, then one extra cycle with data also low.
          if (!ps2_dat_oe) begin
            if (cnt == CW'(INHIBIT_CYCLES - 1)) ps2_dat_oe <= 1'b1;
            else                                cnt        <= cnt + CW'(1);
          end else begin
            ps2_clk_oe <= 1'b0;
            cnt        <= '0;
            state      <= REQ;
          end
        end
        default: begin
          if (!fall && cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_err     <= 1'b1;
            tx_done    <= 1'b1;
            tx_busy    <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= fall ? '0 : cnt + CW'(1);
            case (state)
              REQ, BITS: begin
                // frame[bit_cnt] is on the wire; each fall advances to the next bit, the stop bit releases data.
                if (fall) begin
                  bit_cnt    <= bit_cnt + 4'd1;
                  ps2_dat_oe <= ~frame[bit_cnt + 4'd1];
                  state      <= (bit_cnt == 4'd9) ? ACK : BITS;
                end
              end
              ACK: begin
                if (fall) begin
                  tx_err <= dat_f;
                  state  <= WAIT_IDLE;
                end
              end
              WAIT_IDLE: begin
                if (clk_f && dat_f) begin
                  tx_done <= 1'b1;
                  tx_busy <= 1'b0;
                  state   <= IDLE;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule
